fetch_ctrl: RTL and testbench

Front-end fetch sequencer that sits between the program counter logic and the instruction memory port. It generates sequential fetch addresses and issues them to the memory over a valid/ready request channel, with at most one request outstanding. It accepts responses into a small ordered buffer and presents them to decode over a valid/ready channel. On a redirect it flushes the buffer and discards any stale response still in flight.

---
 rtl/tartaruga_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga front end: bus words, fetch FSM states and
// the entry layout of the fetch response buffer.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        bus32_t pc;
        bus32_t instr;
    } fetch_entry_t;

    localparam int unsigned FETCH_FIFO_DEPTH = 2;
    localparam bus32_t      FETCH_RESET_PC   = 32'h0000_0000;

    // Fetch addresses are word aligned; the low two bits are never honoured.
    function automatic bus32_t align_pc(input bus32_t pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; pointers wrap naturally
// and occupancy is tracked by a separate counter so full and empty are exact.
module fetch_fifo
    import tartaruga_pkg::*;
#(
    parameter  int unsigned DEPTH = FETCH_FIFO_DEPTH,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues sequential word addresses with one request in flight,
// buffers responses for decode and discards stale responses after a redirect.
module fetch_ctrl
    import tartaruga_pkg::*;
#(
    parameter bus32_t      RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         redirect_valid_i,
    input  bus32_t       redirect_pc_i,
    output logic         mem_req_valid_o,
    input  logic         mem_req_ready_i,
    output bus32_t       mem_pc_o,
    input  logic         mem_rsp_valid_i,
    output logic         mem_rsp_ready_o,
    input  bus32_t       mem_rsp_addr_i,
    input  bus32_t       mem_instr_i,
    output logic         fetch_valid_o,
    input  logic         fetch_ready_i,
    output bus32_t       fetch_pc_o,
    output bus32_t       fetch_instr_o,
    output fetch_state_t dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready of the same channel.
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    bus32_t        pc_q, pc_d;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty;
    fetch_entry_t  head, rsp_entry;
    logic          push, pop, flush;
    logic          in_flight, credit;

    // Credit uses registered occupancy only, keeping fetch_ready_i off the request path.
    assign in_flight = (state_q != RUN);
    assign credit    = (32'(count) + 32'(in_flight)) < FIFO_DEPTH;

    assign rsp_entry.pc    = mem_rsp_addr_i;
    assign rsp_entry.instr = mem_instr_i;

    assign mem_pc_o        = pc_q;
    assign mem_rsp_ready_o = rstn_i;
    assign fetch_valid_o   = !fifo_empty && !redirect_valid_i;
    assign pop             = fetch_ready_i && !fifo_empty && !redirect_valid_i;
    assign fetch_pc_o      = fifo_empty ? '0 : head.pc;
    assign fetch_instr_o   = fifo_empty ? '0 : head.instr;
    assign dbg_state_o     = state_q;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        mem_req_valid_o = 1'b0;
        push            = 1'b0;
        flush           = 1'b0;
        if (redirect_valid_i) begin
            flush = 1'b1;
            pc_d  = align_pc(redirect_pc_i);
            if (state_q != RUN) begin
                state_d = mem_rsp_valid_i ? RUN : KILL;
            end
        end else begin
            case (state_q)
                RUN: begin
                    mem_req_valid_o = credit && rstn_i;
                    if (mem_req_valid_o && mem_req_ready_i) begin
                        state_d = WAIT;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        push    = 1'b1;
                        state_d = RUN;
                    end
                end
                KILL: begin
                    if (mem_rsp_valid_i) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (push),
        .push_data_i (rsp_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            fetch_ctrl_unexpected_rsp: assert (!(state_q == RUN && mem_rsp_valid_i))
                else $error("fetch_ctrl: response received with no request in flight");
            fetch_ctrl_push_overflow: assert (!(push && fifo_full && !pop))
                else $error("fetch_ctrl: response pushed into a full buffer");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run, all checked
// against a queue-based model of the fetch stream.
module tb_fetch_ctrl;
    import tartaruga_pkg::*;

    localparam bus32_t      RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 2;

    logic         clk;
    logic         rstn_i;
    logic         redirect_valid_i;
    bus32_t       redirect_pc_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    bus32_t       mem_pc_o;
    logic         mem_rsp_valid_i;
    logic         mem_rsp_ready_o;
    bus32_t       mem_rsp_addr_i;
    bus32_t       mem_instr_i;
    logic         fetch_valid_o;
    logic         fetch_ready_i;
    bus32_t       fetch_pc_o;
    bus32_t       fetch_instr_o;
    fetch_state_t dbg_state_o;

    fetch_ctrl #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_pc_o         (mem_pc_o),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_ready_o  (mem_rsp_ready_o),
        .mem_rsp_addr_i   (mem_rsp_addr_i),
        .mem_instr_i      (mem_instr_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_ready_i    (fetch_ready_i),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_instr_o    (fetch_instr_o),
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model and scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    bus32_t       m_pc   = RST_PC;  // next address to request
    bit           m_pend = 1'b0;    // memory holds a request
    bit           m_keep = 1'b0;    // that request's response belongs to decode
    bus32_t       m_addr = '0;
    int           m_rsp_cyc = 0;
    int           m_lat  = 5;
    fetch_entry_t m_buf[$];         // what decode is owed, in order

    bus32_t req_log[$];
    int     req_cyc_log[$];
    bus32_t dlv_log[$];
    int     dlv_cyc_log[$];
    int     rsp_cyc_log[$];

    function automatic bus32_t instr_of(input bus32_t a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        compared++;
        mismatched++;
        $display("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_cyc_log.delete();
        dlv_log.delete();
        dlv_cyc_log.delete();
        rsp_cyc_log.delete();
    endtask

    // One clock cycle: drive at the falling edge, check settled outputs, then
    // advance the model at the rising edge.
    task automatic tick(input bit rstn, input bit redir, input bus32_t rpc,
                        input bit fready, input bit mready, input bit force_rsp);
        bit           rsp, exp_req, exp_fv, req, pop;
        fetch_state_t es;
        fetch_entry_t e;
        @(negedge clk);
        rsp              = m_pend && (force_rsp || cyc >= m_rsp_cyc);
        rstn_i           = rstn;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        fetch_ready_i    = fready;
        mem_req_ready_i  = mready;
        mem_rsp_valid_i  = rsp;
        mem_rsp_addr_i   = rsp ? m_addr : bus32_t'($urandom);
        mem_instr_i      = rsp ? instr_of(m_addr) : bus32_t'($urandom);
        #1;
        exp_req = rstn && !redir && !m_pend && (m_buf.size() < DEPTH);
        exp_fv  = (m_buf.size() > 0) && !redir;
        es      = !m_pend ? RUN : (m_keep ? WAIT : KILL);
        chk("req_valid", mem_req_valid_o, exp_req);
        chk("req_pc", mem_pc_o, m_pc);
        chk("rsp_ready", mem_rsp_ready_o, rstn);
        chk("fetch_valid", fetch_valid_o, exp_fv);
        chk("state", 32'(dbg_state_o), 32'(es));
        if (exp_fv) begin
            chk("fetch_pc", fetch_pc_o, m_buf[0].pc);
            chk("fetch_instr", fetch_instr_o, m_buf[0].instr);
        end
        req = exp_req && mready;
        pop = exp_fv && fready;
        if (req) begin
            req_log.push_back(m_pc);
            req_cyc_log.push_back(cyc);
        end
        if (pop) begin
            dlv_log.push_back(m_buf[0].pc);
            dlv_cyc_log.push_back(cyc);
        end
        @(posedge clk);
        if (!rstn || redir) begin
            m_buf.delete();
            m_pc   = !rstn ? RST_PC : {rpc[31:2], 2'b00};
            m_keep = 1'b0;
            if (rsp) m_pend = 1'b0;
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (rsp) begin
                m_pend = 1'b0;
                if (m_keep) begin
                    e.pc    = m_addr;
                    e.instr = instr_of(m_addr);
                    m_buf.push_back(e);
                    rsp_cyc_log.push_back(cyc);
                end
            end
            if (req) begin
                m_pend    = 1'b1;
                m_keep    = 1'b1;
                m_addr    = m_pc;
                m_rsp_cyc = cyc + m_lat;
                m_pc      = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit fready);
        tick(1'b1, 1'b0, '0, fready, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        int rel;
        int p;
        rstn_i           = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        mem_req_ready_i  = 1'b0;
        mem_rsp_valid_i  = 1'b0;
        mem_rsp_addr_i   = '0;
        mem_instr_i      = '0;
        fetch_ready_i    = 1'b0;

        // Free run, latency 5, decode always ready.
        m_lat = 5;
        do_reset();
        chk("rst_pc", mem_pc_o, RST_PC);
        chk("rst_fetch_pc", fetch_pc_o, 32'h0);
        chk("rst_fetch_instr", fetch_instr_o, 32'h0);
        clear_logs();
        rel = cyc;
        for (int i = 0; i < 25; i++) step(1'b1);
        if (req_log.size() < 3 || dlv_log.size() < 3 || rsp_cyc_log.size() < 3) begin
            timeout_fail("t1_stream");
        end else begin
            chk("t1_first_req_cycle", req_cyc_log[0], rel);
            for (int i = 0; i < 3; i++) begin
                chk("t1_req_addr", req_log[i], 32'(i * 4));
                chk("t1_dlv_pc", dlv_log[i], 32'(i * 4));
                chk("t1_dlv_latency", dlv_cyc_log[i], rsp_cyc_log[i] + 1);
            end
        end

        // Decode stalled: two requests fill the buffer, then a pop frees one credit.
        m_lat = 2;
        do_reset();
        clear_logs();
        for (int i = 0; i < 20; i++) step(1'b0);
        chk("t2_req_count", req_log.size(), 2);
        p = cyc;
        clear_logs();
        step(1'b1);
        step(1'b0);
        chk("t2_pop_pc", dlv_log.size() > 0 ? dlv_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("t2_next_req_count", req_log.size(), 1);
        chk("t2_next_req_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, 32'h8);
        chk("t2_next_req_cycle", req_cyc_log.size() > 0 ? req_cyc_log[0] : -1, p + 1);

        // Redirect to 0x103 while 0x4 is in flight.
        m_lat = 5;
        do_reset();
        for (int i = 0; i < 40 && !(m_pend && m_addr == 32'h4); i++) step(1'b1);
        if (!(m_pend && m_addr == 32'h4)) timeout_fail("t3_wait_req4");
        step(1'b1);
        clear_logs();
        tick(1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t3_state_kill", 32'(dbg_state_o), 32'(KILL));
        chk("t3_pc_aligned", mem_pc_o, 32'h100);
        for (int i = 0; i < 40 && dlv_log.size() == 0; i++) step(1'b1);
        if (dlv_log.size() == 0 || req_log.size() == 0) begin
            timeout_fail("t3_after_redirect");
        end else begin
            chk("t3_next_req", req_log[0], 32'h100);
            chk("t3_next_dlv", dlv_log[0], 32'h100);
        end

        // Redirect in the same cycle as the response to 0x8.
        m_lat = 3;
        do_reset();
        for (int i = 0; i < 60 && !(m_pend && m_addr == 32'h8 && cyc >= m_rsp_cyc); i++) step(1'b1);
        if (!(m_pend && m_addr == 32'h8 && cyc >= m_rsp_cyc)) timeout_fail("t4_wait_rsp8");
        clear_logs();
        tick(1'b1, 1'b1, 32'h0000_0240, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t4_state_run", 32'(dbg_state_o), 32'(RUN));
        step(1'b1);
        chk("t4_req_next_cycle", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, 32'h240);
        for (int i = 0; i < 40 && dlv_log.size() == 0; i++) step(1'b1);
        chk("t4_first_dlv", dlv_log.size() > 0 ? dlv_log[0] : 32'hDEAD_BEEF, 32'h240);

        // Address wrap at the top of the address space.
        clear_logs();
        tick(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60 && dlv_log.size() < 2; i++) step(1'b1);
        if (req_log.size() < 2 || dlv_log.size() < 2) begin
            timeout_fail("t5_wrap");
        end else begin
            chk("t5_req_top", req_log[0], 32'hFFFF_FFFC);
            chk("t5_req_wrap", req_log[1], 32'h0);
            chk("t5_dlv_wrap", dlv_log[1], 32'h0);
        end

        // Reset pulse with one entry buffered and one request in flight.
        m_lat = 3;
        do_reset();
        for (int i = 0; i < 40 && !(m_pend && m_buf.size() == 1); i++) step(1'b0);
        if (!(m_pend && m_buf.size() == 1)) timeout_fail("t6_setup");
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("t6_req_valid", mem_req_valid_o, 1'b0);
        chk("t6_rsp_ready", mem_rsp_ready_o, 1'b0);
        chk("t6_pc", mem_pc_o, RST_PC);
        chk("t6_fetch_valid", fetch_valid_o, 1'b0);
        chk("t6_fetch_pc", fetch_pc_o, 32'h0);
        chk("t6_fetch_instr", fetch_instr_o, 32'h0);
        chk("t6_state", 32'(dbg_state_o), 32'(RUN));
        clear_logs();
        rel = cyc;
        for (int i = 0; i < 12; i++) step(1'b1);
        chk("t6_restart_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, RST_PC);
        chk("t6_restart_cycle", req_cyc_log.size() > 0 ? req_cyc_log[0] : -1, rel);
        chk("t6_first_dlv", dlv_log.size() > 0 ? dlv_log[0] : 32'hDEAD_BEEF, RST_PC);

        // Randomized traffic: latency, backpressure and redirects all vary.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            m_lat = int'($urandom_range(1, 4));
            tick(1'b1, $urandom_range(0, 19) == 0, bus32_t'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
